// File: rtl/spike_motor_decoder_if.sv
// Bundle between the SNN core, the spike motor decoder and the motor driver.
// Carries the enable, the two excitatory spikes, the latched command and the PWM pins.
interface spike_motor_decoder_if #(
    parameter int PWM_W = 8
);
    logic             en;
    logic [1:0]       spike_in;
    logic             cmd_valid;
    logic [PWM_W-1:0] duty_l;
    logic [PWM_W-1:0] duty_r;
    logic [1:0]       turn;
    logic             pwm_l;
    logic             pwm_r;

    // Upstream/consumer side: drives spikes and enable, observes the command and PWM.
    modport master (
        output en, spike_in,
        input  cmd_valid, duty_l, duty_r, turn, pwm_l, pwm_r
    );

    // Decoder side.
    modport slave (
        input  en, spike_in,
        output cmd_valid, duty_l, duty_r, turn, pwm_l, pwm_r
    );
endinterface

// File: rtl/spike_motor_decoder.sv
// Spike-rate to motor PWM decoder.
// Counts left/right spikes over WIN_LEN enabled cycles, turns the counts into
// saturated duty values with a one-cycle cmd_valid strobe, and drives two
// glitch-free PWM channels whose duty only changes at a period wrap.
// Optional feature macro: SPIKE_DEC_SMOOTH_EN (duty = average of old duty and new raw).
module spike_motor_decoder #(
    parameter int WIN_LEN = 1024,
    parameter int CNT_W   = 11,
    parameter int SHIFT   = 2,
    parameter int PWM_W   = 8
) (
    input logic                 clk,
    input logic                 rst,
    spike_motor_decoder_if.slave bus
);
    localparam int WIN_W = (WIN_LEN > 2) ? $clog2(WIN_LEN) : 1;
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_LEN - 1);
    localparam int unsigned PWM_MAX = (2 ** PWM_W) - 1;

    typedef enum logic {IDLE = 1'b0, COUNT = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
    logic [CNT_W-1:0] cnt_l_q, cnt_l_d, cnt_r_q, cnt_r_d;
    logic             close_q, close_d;
    logic [PWM_W-1:0] raw_l_q, raw_l_d, raw_r_q, raw_r_d;
    logic             cmd_valid_q, cmd_valid_d;
    logic [PWM_W-1:0] duty_l_q, duty_l_d, duty_r_q, duty_r_d;
    logic [1:0]       turn_q, turn_d;
    logic [PWM_W-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [PWM_W-1:0] shad_l_q, shad_l_d, shad_r_q, shad_r_d;
    logic             pwm_l_q, pwm_l_d, pwm_r_q, pwm_r_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic hit);
        if (hit && (c != {CNT_W{1'b1}})) return c + CNT_W'(1);
        return c;
    endfunction

    function automatic logic [PWM_W-1:0] sat_raw(input logic [CNT_W-1:0] c);
        logic [CNT_W-1:0] s;
        int unsigned      v;
        s = c >> SHIFT;
        v = 32'(s);
        if (v > PWM_MAX) return {PWM_W{1'b1}};
        return PWM_W'(v);
    endfunction

    function automatic logic [PWM_W-1:0] next_duty(input logic [PWM_W-1:0] d,
                                                   input logic [PWM_W-1:0] r);
`ifdef SPIKE_DEC_SMOOTH_EN
        logic [PWM_W:0] sum;
        sum = {1'b0, d} + {1'b0, r};
        return sum[PWM_W:1];
`else
        logic unused_d;
        unused_d = ^d;
        return r;
`endif
    endfunction

    // Next-state logic: window/spike counting, duty update stage and PWM.
    always_comb begin
        logic [CNT_W-1:0] inc_l, inc_r;
        state_d     = state_q;
        win_cnt_d   = win_cnt_q;
        cnt_l_d     = cnt_l_q;
        cnt_r_d     = cnt_r_q;
        close_d     = 1'b0;
        raw_l_d     = raw_l_q;
        raw_r_d     = raw_r_q;
        pwm_cnt_d   = pwm_cnt_q;
        shad_l_d    = shad_l_q;
        shad_r_d    = shad_r_q;
        inc_l       = sat_inc(cnt_l_q, bus.spike_in[0]);
        inc_r       = sat_inc(cnt_r_q, bus.spike_in[1]);

        // Counting is identical in IDLE and COUNT; the first en cycle is position 0.
        if (bus.en) begin
            state_d = COUNT;
            if (win_cnt_q == WIN_LAST) begin
                // Closing-cycle spike belongs to the closing window.
                win_cnt_d = '0;
                close_d   = 1'b1;
                raw_l_d   = sat_raw(inc_l);
                raw_r_d   = sat_raw(inc_r);
                cnt_l_d   = '0;
                cnt_r_d   = '0;
            end else begin
                win_cnt_d = win_cnt_q + WIN_W'(1);
                cnt_l_d   = inc_l;
                cnt_r_d   = inc_r;
            end

            pwm_cnt_d = pwm_cnt_q + PWM_W'(1);
            // Shadows take the currently latched duty at the wrap, so a duty
            // published on the same edge lands one period later.
            if (pwm_cnt_q == {PWM_W{1'b1}}) begin
                shad_l_d = duty_l_q;
                shad_r_d = duty_r_q;
            end
        end

        // Duty/turn stage runs one edge after the close, independent of en.
        cmd_valid_d = close_q;
        duty_l_d    = duty_l_q;
        duty_r_d    = duty_r_q;
        turn_d      = turn_q;
        if (close_q) begin
            duty_l_d = next_duty(duty_l_q, raw_l_q);
            duty_r_d = next_duty(duty_r_q, raw_r_q);
            if (duty_l_d > duty_r_d)      turn_d = 2'b01;
            else if (duty_r_d > duty_l_d) turn_d = 2'b10;
            else                          turn_d = 2'b00;
        end

        pwm_l_d = bus.en && (pwm_cnt_q < shad_l_q);
        pwm_r_d = bus.en && (pwm_cnt_q < shad_r_q);
    end

    // State register with synchronous active-low reset; discards any partial window.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            win_cnt_q   <= '0;
            cnt_l_q     <= '0;
            cnt_r_q     <= '0;
            close_q     <= 1'b0;
            raw_l_q     <= '0;
            raw_r_q     <= '0;
            cmd_valid_q <= 1'b0;
            duty_l_q    <= '0;
            duty_r_q    <= '0;
            turn_q      <= 2'b00;
            pwm_cnt_q   <= '0;
            shad_l_q    <= '0;
            shad_r_q    <= '0;
            pwm_l_q     <= 1'b0;
            pwm_r_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            win_cnt_q   <= win_cnt_d;
            cnt_l_q     <= cnt_l_d;
            cnt_r_q     <= cnt_r_d;
            close_q     <= close_d;
            raw_l_q     <= raw_l_d;
            raw_r_q     <= raw_r_d;
            cmd_valid_q <= cmd_valid_d;
            duty_l_q    <= duty_l_d;
            duty_r_q    <= duty_r_d;
            turn_q      <= turn_d;
            pwm_cnt_q   <= pwm_cnt_d;
            shad_l_q    <= shad_l_d;
            shad_r_q    <= shad_r_d;
            pwm_l_q     <= pwm_l_d;
            pwm_r_q     <= pwm_r_d;
        end
    end

    assign bus.cmd_valid = cmd_valid_q;
    assign bus.duty_l    = duty_l_q;
    assign bus.duty_r    = duty_r_q;
    assign bus.turn      = turn_q;
    assign bus.pwm_l     = pwm_l_q;
    assign bus.pwm_r     = pwm_r_q;
endmodule
